myproject_dense_acc_sat: RTL and testbench

//  Downstream consumer of the signed product multipliers in a dense layer. It accumulates
//  N_TERMS signed products, adds a per-neuron bias, then rounds and saturates the sum to the

---
 rtl/myproject_acc_pkg.sv | 22 ++
 rtl/myproject_round_sat.sv | 41 ++++
 rtl/myproject_dense_acc_sat.sv | 118 +++++++++++
 tb/tb_myproject_dense_acc_sat.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/myproject_acc_pkg.sv
// Shared types and constants for the dense-layer accumulate/round/saturate stage.
// The optional ReLU clamp is selected by the MYPROJECT_ACC_RELU_EN macro (see myproject_round_sat).
package myproject_acc_pkg;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_e;

    localparam int OUT_W_DEF = 16;
    localparam int OUT_MAX   = 2 ** (OUT_W_DEF - 1) - 1;
    localparam int OUT_MIN   = -(2 ** (OUT_W_DEF - 1));

    // Smallest accumulator that can never wrap for the given term/bias shapes.
    function automatic int acc_w_min(input int prod_w, input int bias_w,
                                     input int frac_shift, input int n_terms);
        int widest;
        widest = (prod_w > bias_w + frac_shift) ? prod_w : bias_w + frac_shift;
        return widest + $clog2(n_terms) + 1;
    endfunction

endpackage

// File: rtl/myproject_round_sat.sv
// Combinational half-up round and saturate from ACC_W to OUT_W, with clip flag.
// Define MYPROJECT_ACC_RELU_EN to clamp negative results to zero (flag cleared).
module myproject_round_sat #(
    parameter int ACC_W      = 28,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 6
) (
    input  logic signed [ACC_W-1:0] acc_dat,
    output logic signed [OUT_W-1:0] res_dat,
    output logic                    res_sat
);

    // One guard bit so the rounding increment can never overflow.
    localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(2 ** (FRAC_SHIFT - 1));
    localparam logic signed [ACC_W:0] MAX_EXT = (ACC_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W:0] MIN_EXT = (ACC_W+1)'(-(2 ** (OUT_W - 1)));

    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] rnd;

    always_comb begin
        sum     = {acc_dat[ACC_W-1], acc_dat} + HALF;
        rnd     = sum >>> FRAC_SHIFT;
        res_dat = rnd[OUT_W-1:0];
        res_sat = 1'b0;
        if (rnd > MAX_EXT) begin
            res_dat = MAX_EXT[OUT_W-1:0];
            res_sat = 1'b1;
        end else if (rnd < MIN_EXT) begin
            res_dat = MIN_EXT[OUT_W-1:0];
            res_sat = 1'b1;
        end
`ifdef MYPROJECT_ACC_RELU_EN
        if (rnd[ACC_W]) begin
            res_dat = '0;
            res_sat = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/myproject_dense_acc_sat.sv
// Dense-layer neuron accumulator: sums N_TERMS products plus bias, rounds/saturates, streams out.
// Optional ReLU output clamp via MYPROJECT_ACC_RELU_EN (implemented in myproject_round_sat).
module myproject_dense_acc_sat
    import myproject_acc_pkg::*;
#(
    parameter int PROD_W     = 22,
    parameter int BIAS_W     = 16,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 6,
    parameter int N_TERMS    = 16,
    parameter int ACC_W      = 28
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic signed [PROD_W-1:0] prod_dat,
    input  logic                     prod_vld,
    output logic                     prod_rdy,
    input  logic signed [BIAS_W-1:0] bias_dat,
    output logic signed [OUT_W-1:0]  out_dat,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_sat
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

    if (ACC_W < acc_w_min(PROD_W, BIAS_W, FRAC_SHIFT, N_TERMS)) begin : g_acc_w_check
        $error("ACC_W too small for the configured term and bias widths");
    end

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [OUT_W-1:0]   out_dat_q, out_dat_d;
    logic                      out_vld_q, out_vld_d;
    logic                      out_sat_q, out_sat_d;

    logic signed [ACC_W-1:0]   term_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [OUT_W-1:0]   rs_dat;
    logic                      rs_sat;
    logic                      accept;

    assign term_ext = {{(ACC_W-PROD_W){prod_dat[PROD_W-1]}}, prod_dat};
    assign bias_ext = {{(ACC_W-BIAS_W-FRAC_SHIFT){bias_dat[BIAS_W-1]}}, bias_dat,
                       {FRAC_SHIFT{1'b0}}};
    // The first term of a neuron restarts the sum from the scaled bias.
    assign acc_sum  = ((cnt_q == '0) ? bias_ext : acc_q) + term_ext;
    assign accept   = prod_vld && (state_q == ST_ACC);

    myproject_round_sat #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_round_sat (
        .acc_dat (acc_sum),
        .res_dat (rs_dat),
        .res_sat (rs_sat)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        out_dat_d = out_dat_q;
        out_vld_d = out_vld_q;
        out_sat_d = out_sat_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    acc_d = acc_sum;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        state_d   = ST_OUT;
                        out_vld_d = 1'b1;
                        out_dat_d = rs_dat;
                        out_sat_d = rs_sat;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_OUT: begin
                if (out_rdy) begin
                    out_vld_d = 1'b0;
                    state_d   = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= ST_ACC;
            cnt_q     <= '0;
            acc_q     <= '0;
            out_dat_q <= '0;
            out_vld_q <= 1'b0;
            out_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            out_dat_q <= out_dat_d;
            out_vld_q <= out_vld_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign prod_rdy = (state_q == ST_ACC);
    assign out_dat  = out_dat_q;
    assign out_vld  = out_vld_q;
    assign out_sat  = out_sat_q;

endmodule

// File: tb/tb_myproject_dense_acc_sat.sv
// Scoreboard bench for myproject_dense_acc_sat with N_TERMS=4, FRAC_SHIFT=6, OUT_W=16.
module tb_myproject_dense_acc_sat;
    import myproject_acc_pkg::*;

    typedef struct {
        int   dat;
        logic sat;
    } exp_t;

    logic                ap_clk = 1'b0;
    logic                ap_rst_n = 1'b0;
    logic signed [21:0]  prod_dat = '0;
    logic                prod_vld = 1'b0;
    logic                prod_rdy;
    logic signed [15:0]  bias_dat = '0;
    logic signed [15:0]  out_dat;
    logic                out_vld;
    logic                out_rdy = 1'b1;
    logic                out_sat;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_outputs = 0;
    int   n_pushed = 0;

    always #5 ap_clk = ~ap_clk;

    myproject_dense_acc_sat #(
        .PROD_W(22), .BIAS_W(16), .OUT_W(16), .FRAC_SHIFT(6), .N_TERMS(4), .ACC_W(28)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .prod_dat (prod_dat),
        .prod_vld (prod_vld),
        .prod_rdy (prod_rdy),
        .bias_dat (bias_dat),
        .out_dat  (out_dat),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_sat  (out_sat)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int dat, input logic sat);
        exp_t e;
        e.dat = dat;
        e.sat = sat;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    // Monitor: each handshake pops the oldest expected result.
    always @(negedge ap_clk) begin
        if (ap_rst_n && out_vld && out_rdy) begin
            n_outputs++;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_dat", out_dat, e.dat);
                chk("out_sat", out_sat, e.sat);
            end
        end
    end

    // Present one term and return #1 after the edge that accepts it.
    task automatic send_term(input int t, input int b);
        int guard;
        guard = 0;
        prod_dat = 22'(t);
        bias_dat = 16'(b);
        prod_vld = 1'b1;
        while (!prod_rdy && guard < 50) begin
            @(posedge ap_clk);
            #1;
            guard++;
        end
        if (guard >= 50) chk("prod_rdy_timeout", 0, 1);
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send_neuron(input int b, input int t0, input int t1, input int t2, input int t3);
        send_term(t0, b);
        send_term(t1, b);
        send_term(t2, b);
        send_term(t3, b);
        prod_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((out_vld || exp_q.size() != 0) && guard < 50) begin
            @(posedge ap_clk);
            #1;
            guard++;
        end
        if (guard >= 50) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_dat", out_dat, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_prod_rdy", prod_rdy, 1);
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Continuous valid, latency check on the last term.
        push_exp(4, 1'b0);
        send_term(64, 0);
        send_term(64, 0);
        send_term(64, 0);
        chk("lat_vld_before_last", out_vld, 0);
        send_term(64, 0);
        chk("lat_vld_after_last", out_vld, 1);
        chk("lat_prod_rdy_low", prod_rdy, 0);
        prod_vld = 1'b0;
        wait_idle();

        // Half-up rounding around zero.
        push_exp(1, 1'b0);
        send_neuron(0, 32, 0, 0, 0);
        push_exp(0, 1'b0);
        send_neuron(0, -32, 0, 0, 0);
        push_exp(-1, 1'b0);
        send_neuron(0, -33, 0, 0, 0);
        wait_idle();

        // Bias: (5*64 + 128 + 32) >> 6 = 7.
        push_exp(7, 1'b0);
        send_neuron(5, 64, -64, 128, 0);
        wait_idle();

        // Saturation both directions.
        push_exp(OUT_MAX, 1'b1);
        send_neuron(0, 2097151, 2097151, 2097151, 2097151);
`ifdef MYPROJECT_ACC_RELU_EN
        push_exp(0, 1'b0);
`else
        push_exp(OUT_MIN, 1'b1);
`endif
        send_neuron(0, -2097152, -2097152, -2097152, -2097152);
        wait_idle();

        // Backpressure: result held, no terms taken until the handshake.
        out_rdy = 1'b0;
        push_exp(4, 1'b0);
        send_neuron(0, 64, 64, 64, 64);
        push_exp(1, 1'b0);
        prod_dat = 22'(64);
        bias_dat = '0;
        prod_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_prod_rdy", prod_rdy, 0);
            chk("bp_out_vld", out_vld, 1);
            chk("bp_out_dat", out_dat, 4);
            @(posedge ap_clk);
            #1;
        end
        out_rdy = 1'b1;
        @(posedge ap_clk);
        #1;
        chk("bp_vld_dropped", out_vld, 0);
        chk("bp_prod_rdy_back", prod_rdy, 1);
        send_neuron(0, 64, 0, 0, 0);
        wait_idle();

        // Reset mid-neuron discards the partial sum.
        send_term(64, 3);
        send_term(64, 3);
        prod_vld = 1'b0;
        ap_rst_n = 1'b0;
        #2;
        chk("mid_rst_prod_rdy", prod_rdy, 1);
        chk("mid_rst_out_vld", out_vld, 0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        push_exp(4, 1'b0);
        send_neuron(0, 64, 64, 64, 64);
        wait_idle();
        repeat (5) @(posedge ap_clk);
        #1;

        chk("queue_drained", exp_q.size(), 0);
        chk("output_count", n_outputs, n_pushed);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
